sel_decode_pipe: RTL and testbench
==================================

# sel_decode_pipe

Registered, multi-channel select-to-code decoder with a zero-code flag per channel. It is the parametrised successor to the team's single-channel combinational case decoder. Each accepted beat is decoded under a runtime mode and queued in a small output FIFO with valid/ready flow control. A saturating counter of zero-code beats is kept for synthesis-vs-simulation cross-checks in the regression benches.

## Interface
Parameters:
- WIDTH, 2: bits per channel select/code (≥1)
- CHANNELS, 1: independent decode lanes per beat (≥1)
- DEPTH, 2: output FIFO entries (power of 2, ≥2)
- DEFAULT, 0: code emitted for an all-ones select (WIDTH bits)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  FIFO can accept (= not full)
- in_sel  in  CHANNELS*WIDTH  selects, channel 0 in LSBs
- in_mode  in  2  decode mode for this beat
- out_valid  out  1  FIFO head valid (= not empty)
- out_ready  in  1  consumer takes head
- out_code  out  CHANNELS*WIDTH  decoded codes at head
- out_flag  out  CHANNELS  per-channel code==0 at head
- clr_count  in  1  synchronous clear of zero_count
- zero_count  out  16  beats accepted with any flag set, saturating

## Operation
- Accept when in_valid && in_ready; pop when out_valid && out_ready.
- Per channel, code starts at DEFAULT; the mode then overrides:
  - 00 INV: ~sel, except sel all-ones keeps DEFAULT.
  - 01 PASS: sel.
  - 10 REV: bit-reversed sel.
  - 11 FORCE: DEFAULT for every channel.
- flag[c] = (code[c] == 0), computed after the override and stored with the code. It is never stale.
- Decode is combinational at the input; the code and flag are written together into one FIFO entry.
- Empty: out_valid=0; out_code and out_flag read 0 (not stale memory).
- Full: in_ready=0 even if a pop occurs the same cycle; no combinational out_ready→in_ready path.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty use an extra wrap bit.
- zero_count increments on each accepted beat with |flag. It holds at 16'hFFFF.
- clr_count wins over an increment in the same cycle (result 0).

## Timing
- Reset (async assert, sync-safe deassert) values: pointers 0, zero_count 0, out_valid 0, in_ready 1, out_code 0, out_flag 0.
- Latency: a beat accepted at edge N appears at the head after edge N if the FIFO was empty, i.e. out_valid=1 in cycle N+1.
- Throughput: one beat per cycle when the consumer holds out_ready=1.
- Reset mid-stream discards all queued entries; no partial beat survives.
- in_mode and in_sel are sampled only on acceptance; changes while in_ready=0 are ignored.

## Structure
- Package sel_decode_pkg:
  - mode constants MODE_INV, MODE_PASS, MODE_REV, MODE_FORCE;
  - decode function (sel, mode, DEFAULT) → code;
  - count width constant CNT_W=16.
- Sub-module sel_decode_fifo: generic DEPTH×(CHANNELS*(WIDTH+1)) sync FIFO with valid/ready and zero-when-empty output.
- Top level: decode lanes, FIFO instance, zero counter.

## Test plan
- WIDTH=2, CHANNELS=1, mode INV, sel 0,1,2,3 with out_ready=1 → codes 3,2,1,0; flags 0,0,0,1; zero_count=1.
- CHANNELS=2, mode REV, in_sel=4'b0110 (ch0=2'b10, ch1=2'b01) → out_code=4'b1001; out_flag=2'b00.
- Mode FORCE with DEFAULT=0, 3 beats → all flags 1; zero_count=3. Hold clr_count and accept a flagged beat in the same cycle → zero_count=0.
- DEPTH=2, out_ready=0, push 3 beats → in_ready drops after 2. Third beat is accepted only after one pop; order preserved across pointer wrap.
- Drain to empty → out_valid=0 and out_code=0. Assert rst with 2 entries queued → out_valid=0, zero_count=0, in_ready=1 immediately.
- Force zero_count to 16'hFFFE, accept 3 flagged beats → zero_count=16'hFFFF and holds.

Source files
------------

// File: rtl/sel_decode_pkg.sv
// rtl/sel_decode_pkg.sv - decode modes, counter width and the per-lane select-to-code function
package sel_decode_pkg;

  localparam int CNT_W = 16;
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    MODE_INV   = 2'b00,
    MODE_PASS  = 2'b01,
    MODE_REV   = 2'b10,
    MODE_FORCE = 2'b11
  } mode_e;

  // Operates right-aligned in MAX_W bits; only the low 'width' bits are meaningful.
  function automatic logic [MAX_W-1:0] decode(input logic [MAX_W-1:0] sel,
                                              input logic [1:0]       mode,
                                              input logic [MAX_W-1:0] dflt,
                                              input int               width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] rev;
    logic [MAX_W-1:0] code;
    logic             all_ones;
    mask     = {MAX_W{1'b1}} >> (MAX_W - width);
    rev      = {<<{sel}} >> (MAX_W - width);
    all_ones = ((sel & mask) == mask);
    case (mode)
      MODE_INV:  code = all_ones ? dflt : ~sel;
      MODE_PASS: code = sel;
      MODE_REV:  code = rev;
      default:   code = dflt;
    endcase
    return code & mask;
  endfunction

endpackage

// File: rtl/sel_decode_fifo.sv
// rtl/sel_decode_fifo.sv - DEPTH-entry sync FIFO with valid/ready and zero data when empty
module sel_decode_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  assign out_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sel_decode_pipe.sv
// rtl/sel_decode_pipe.sv - multi-lane select decoder feeding an output FIFO, with a saturating zero-code counter
module sel_decode_pipe
  import sel_decode_pkg::*;
#(
  parameter int               WIDTH    = 2,
  parameter int               CHANNELS = 1,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] DEFAULT  = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_sel,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_code,
  output logic [CHANNELS-1:0]       out_flag,
  input  logic                      clr_count,
  output logic [CNT_W-1:0]          zero_count
);

  logic [CHANNELS*WIDTH-1:0] code;
  logic [CHANNELS-1:0]       flag;
  logic                      accept;
  logic [CNT_W-1:0]          zero_count_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign code[c*WIDTH +: WIDTH] = WIDTH'(decode(MAX_W'(in_sel[c*WIDTH +: WIDTH]), in_mode,
                                                  MAX_W'(DEFAULT), WIDTH));
    assign flag[c] = (code[c*WIDTH +: WIDTH] == '0);
  end

  sel_decode_fifo #(
    .DW    (CHANNELS*(WIDTH+1)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({flag, code}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_flag, out_code})
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_count_q <= '0;
    end else if (clr_count) begin
      zero_count_q <= '0;
    end else if (accept && (|flag) && (zero_count_q != {CNT_W{1'b1}})) begin
      zero_count_q <= zero_count_q + 1'b1;
    end
  end

  assign zero_count = zero_count_q;

endmodule

// File: tb/tb_sel_decode_pipe.sv
// tb/tb_sel_decode_pipe.sv - table-driven and scoreboarded bench for sel_decode_pipe (WIDTH=2, CHANNELS=2, DEPTH=2)
module tb_sel_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_code;
  logic [1:0]  out_flag;
  logic        clr_count;
  logic [15:0] zero_count;

  int n_assert = 0;
  int n_fail   = 0;
  logic [5:0] exp_q [$];

  typedef struct {
    logic [3:0]  sel;
    logic [1:0]  mode;
    logic [3:0]  code;
    logic [1:0]  flag;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  sel_decode_pipe #(.WIDTH(2), .CHANNELS(2), .DEPTH(2), .DEFAULT(2'b00)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_flag   (out_flag),
    .clr_count  (clr_count),
    .zero_count (zero_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] mdl(input logic [1:0] s, input logic [1:0] m);
    case (m)
      2'b00:   return (s == 2'b11) ? 2'b00 : ~s;
      2'b01:   return s;
      2'b10:   return {s[0], s[1]};
      default: return 2'b00;
    endcase
  endfunction

  // Scoreboard consumer: every popped head must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {26'd0, out_flag, out_code}, 32'hdead);
      end else begin
        chk("head", {26'd0, out_flag, out_code}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  // Called at #1 after a rising edge; returns #1 after the edge that accepted the beat.
  task automatic send(input logic [3:0] s, input logic [1:0] m,
                      input logic [3:0] c, input logic [1:0] f);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_sel   = s;
    in_mode  = m;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    else exp_q.push_back({f, c});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [3:0]  rs;
    logic [1:0]  rm;
    logic [3:0]  rc;
    logic [1:0]  rf;
    logic [15:0] mcnt;

    tbl[0] = '{4'b0000, 2'b00, 4'b1111, 2'b00, 16'd0};
    tbl[1] = '{4'b0101, 2'b00, 4'b1010, 2'b00, 16'd0};
    tbl[2] = '{4'b1010, 2'b00, 4'b0101, 2'b00, 16'd0};
    tbl[3] = '{4'b1111, 2'b00, 4'b0000, 2'b11, 16'd1};
    tbl[4] = '{4'b0110, 2'b10, 4'b1001, 2'b00, 16'd1};
    tbl[5] = '{4'b1100, 2'b01, 4'b1100, 2'b01, 16'd2};
    tbl[6] = '{4'b0011, 2'b00, 4'b1100, 2'b01, 16'd3};
    tbl[7] = '{4'b1101, 2'b10, 4'b1110, 2'b00, 16'd3};

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_mode = '0;
    out_ready = 1'b1; clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_flag", out_flag, 0);
    chk("rst_zero_count", zero_count, 0);

    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].sel, tbl[i].mode, tbl[i].code, tbl[i].flag);
      if (i == 0) chk("latency_out_valid", out_valid, 1);
      chk("tbl_zero_count", zero_count, tbl[i].cnt);
    end
    drain();

    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("clr_zero_count", zero_count, 0);
    for (int i = 0; i < 3; i++) send(4'(i * 5), 2'b11, 4'b0000, 2'b11);
    chk("force_zero_count", zero_count, 3);
    clr_count = 1'b1;
    send(4'b0110, 2'b11, 4'b0000, 2'b11);
    clr_count = 1'b0;
    chk("clr_wins_count", zero_count, 0);
    drain();

    out_ready = 1'b0;
    send(4'b0110, 2'b01, 4'b0110, 2'b00);
    send(4'b1001, 2'b01, 4'b1001, 2'b00);
    in_valid = 1'b1; in_sel = 4'b0000; in_mode = 2'b00;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_pop_in_ready", in_ready, 1);
    send(4'b0001, 2'b10, 4'b0010, 2'b10);
    drain();
    @(negedge clk);
    chk("empty_out_valid", out_valid, 0);
    chk("empty_out_code", out_code, 0);
    chk("empty_out_flag", out_flag, 0);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'b0000, 2'b11, 4'b0000, 2'b11);
    send(4'b0000, 2'b11, 4'b0000, 2'b11);
    chk("pre_rst_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_zero_count", zero_count, 0);
    chk("mid_rst_out_code", out_code, 0);
    exp_q.delete();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out_valid", out_valid, 0);

    mcnt = 16'd0;
    for (int i = 0; i < 24; i++) begin
      rs = 4'($urandom_range(0, 15));
      rm = 2'($urandom_range(0, 3));
      rc = {mdl(rs[3:2], rm), mdl(rs[1:0], rm)};
      rf = {rc[3:2] == 2'b00, rc[1:0] == 2'b00};
      if (rf != 2'b00) mcnt++;
      out_ready = ($urandom_range(0, 3) != 0);
      send(rs, rm, rc, rf);
    end
    drain();
    chk("rand_zero_count", zero_count, mcnt);

    force dut.zero_count_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.zero_count_q;
    chk("sat_preload", zero_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      send(4'b1111, 2'b11, 4'b0000, 2'b11);
      chk("sat_zero_count", zero_count, 16'hFFFF);
    end
    drain();
    repeat (2) @(posedge clk);
    #1 chk("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
